// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle controller and its datapath: opcodes,
// funct fields, ALU operation codes and the FSM state encoding.
package multicycle_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALUOP_AND = 4'b0000;
    localparam logic [3:0] ALUOP_OR  = 4'b0001;
    localparam logic [3:0] ALUOP_ADD = 4'b0010;
    localparam logic [3:0] ALUOP_SUB = 4'b0110;
    localparam logic [3:0] ALUOP_SLT = 4'b0111;
    localparam logic [3:0] ALUOP_SRL = 4'b1000;
    localparam logic [3:0] ALUOP_SLL = 4'b1001;
    localparam logic [3:0] ALUOP_SRA = 4'b1010;
    localparam logic [3:0] ALUOP_XOR = 4'b1101;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_e;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    // funct3 mapping shared by R-type (funct7 = base) and I-type arithmetic.
    function automatic logic [3:0] base_alu_op(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return ALUOP_ADD;
            F3_SLL:  return ALUOP_SLL;
            F3_SLT:  return ALUOP_SLT;
            F3_XOR:  return ALUOP_XOR;
            F3_SR:   return ALUOP_SRL;
            F3_OR:   return ALUOP_OR;
            F3_AND:  return ALUOP_AND;
            default: return ALUOP_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode from opcode/funct3/funct7.
// Unrecognised encodings produce the AND code (0000).
module alu_decoder
    import multicycle_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALUOP_AND;
        case (opcode)
            OP_LOAD, OP_STORE: alu_ctrl = ALUOP_ADD;
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) alu_ctrl = ALUOP_SUB;
            end
            OP_RTYPE: begin
                if (funct7 == F7_BASE) begin
                    alu_ctrl = base_alu_op(funct3);
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == F3_ADD) alu_ctrl = ALUOP_SUB;
                    else if (funct3 == F3_SR) alu_ctrl = ALUOP_SRA;
                end
            end
            // Immediate shifts carry shamt/funct7 in the immediate; only R-type selects SRA.
            OP_ITYPE: alu_ctrl = base_alu_op(funct3);
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_fsm_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB control FSM with sticky trap causes and a MEM wait timeout.
// Define MULTICYCLE_PERF_EN to build the cycle/instret performance counters.
module multicycle_fsm_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             iReady,
    input  logic             dReady,
    input  logic             Zero,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             loadPC,
    output logic             ALUSrc,
    output logic             MemToReg,
    output logic             PCSrc,
    output logic [3:0]       ALUCtrl,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    // The counter only has to reach WAIT_TIMEOUT-1: that cycle either traps or completes.
    localparam int unsigned    TO_W    = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(WAIT_TIMEOUT - 1);
    localparam bit             TO_EN   = (WAIT_TIMEOUT != 0);

    state_e            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    logic [6:0] opcode;
    logic       is_rtype, is_itype, is_load, is_store, is_branch;
    logic       ir_unused;

    assign opcode    = ir_q[6:0];
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_itype  = (opcode == OP_ITYPE);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign ir_unused = ^{ir_q[24:15], ir_q[11:7]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IF;
            ir_q      <= '0;
            to_cnt_q  <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            to_cnt_q  <= to_cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        to_cnt_d  = to_cnt_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        loadPC    = 1'b0;
        case (state_q)
            S_IF: begin
                if (iReady) begin
                    ir_d    = instr;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (is_legal_op(opcode)) begin
                    state_d = S_EX;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end
            S_EX: begin
                if (is_load || is_store) begin
                    state_d  = S_MEM;
                    to_cnt_d = '0;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                MemRead  = is_load;
                MemWrite = is_store;
                // A completing handshake beats a timeout landing in the same cycle.
                if (dReady) begin
                    state_d = S_WB;
                end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_WB: begin
                loadPC   = 1'b1;
                RegWrite = is_rtype || is_itype || is_load;
                state_d  = S_IF;
            end
            S_TRAP: ;
            default: state_d = S_TRAP;
        endcase
    end

    alu_decoder u_alu_decoder (
        .opcode   (opcode),
        .funct3   (ir_q[14:12]),
        .funct7   (ir_q[31:25]),
        .alu_ctrl (ALUCtrl)
    );

    assign ALUSrc   = is_itype || is_load || is_store;
    assign MemToReg = is_load;
    assign PCSrc    = is_branch && Zero;
    assign state    = state_q;
    assign illegal  = illegal_q;
    assign bus_err  = bus_err_q;

`ifdef MULTICYCLE_PERF_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_TRAP) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        if (state_q == S_WB) instret_cnt_d = instret_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
